// File: rtl/mem_bus_master.sv
// Initiator for the byte-wide memory port: turns byte/word requests into one or two
// single-cycle memory accesses (little-endian) and returns data/error on a response handshake.
module mem_bus_master #(
    parameter logic [15:0] MEM_TOP = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_word,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_ce,
    output logic        mem_w,
    output logic        mem_r,
    output logic        mem_oe,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_write;
    logic        r_word;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    logic        r_err;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic        r_busy;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic        r_ce;
    logic        r_w;
    logic        r_rd;

    // 17-bit last-byte address so a word at 0xFFFF cannot wrap back into range
    logic [16:0] w_last_byte;
    logic        w_in_range;

    assign w_last_byte = {1'b0, req_addr} + {16'd0, req_word};
    assign w_in_range  = (w_last_byte <= {1'b0, MEM_TOP});

    // Request sequencing FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_write      <= 1'b0;
            r_word       <= 1'b0;
            r_addr       <= 16'd0;
            r_wdata      <= 16'd0;
            r_rdata      <= 16'd0;
            r_err        <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_mem_addr   <= 16'd0;
            r_mem_wdata  <= 8'd0;
            r_ce         <= 1'b0;
            r_w          <= 1'b0;
            r_rd         <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_word      <= req_word;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_rdata     <= 16'd0;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_in_range) begin
                            r_state     <= ACC_LO;
                            r_err       <= 1'b0;
                            r_mem_addr  <= req_addr;
                            r_mem_wdata <= req_wdata[7:0];
                            r_ce        <= 1'b1;
                            r_w         <= req_write;
                            r_rd        <= ~req_write;
                        end else begin
                            r_state      <= RESP;
                            r_err        <= 1'b1;
                            r_resp_valid <= 1'b1;
                        end
                    end
                end
                ACC_LO: begin
                    if (!r_write) begin
                        r_rdata[7:0] <= mem_rdata;
                    end
                    if (r_word) begin
                        r_state     <= ACC_HI;
                        r_mem_addr  <= r_addr + 16'd1;
                        r_mem_wdata <= r_wdata[15:8];
                    end else begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_ce         <= 1'b0;
                        r_w          <= 1'b0;
                        r_rd         <= 1'b0;
                    end
                end
                ACC_HI: begin
                    if (!r_write) begin
                        r_rdata[15:8] <= mem_rdata;
                    end
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                    r_ce         <= 1'b0;
                    r_w          <= 1'b0;
                    r_rd         <= 1'b0;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_busy       <= 1'b0;
                    r_ce         <= 1'b0;
                    r_w          <= 1'b0;
                    r_rd         <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign busy       = r_busy;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

    // Strobes are masked by reset in the same cycle so a reset edge can never write memory
    assign mem_ce = r_ce & rst;
    assign mem_w  = r_w  & rst;
    assign mem_r  = r_rd & rst;
    assign mem_oe = r_rd & rst;

endmodule

// File: tb/tb_mem_bus_master.sv
// Randomized bench for mem_bus_master: a byte-array memory model on the bus plus a
// transaction-level reference model (range rule, little-endian words, latency).
module tb_mem_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_word;
    logic [15:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [15:0] resp_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ce, mem_w, mem_r, mem_oe, busy;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem_arr [0:65535];
    bit         mem_wr  [0:65535];
    logic [7:0] ref_mem [0:65535];

    always #5 clk = ~clk;

    mem_bus_master #(.MEM_TOP(16'd1024)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_word(req_word), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ce(mem_ce), .mem_w(mem_w), .mem_r(mem_r), .mem_oe(mem_oe),
        .busy(busy)
    );

    function automatic logic [7:0] seed_byte(input logic [15:0] a);
        return a[7:0] ^ {a[10:8], a[15:11]} ^ 8'h5C;
    endfunction

    function automatic logic [7:0] tb_mem_byte(input logic [15:0] a);
        return mem_wr[a] ? mem_arr[a] : seed_byte(a);
    endfunction

    // Memory model: write on posedge when ce&w
    always @(posedge clk) begin
        if (mem_ce && mem_w) begin
            mem_arr[mem_addr] <= mem_wdata;
            mem_wr[mem_addr]  <= 1'b1;
        end
    end

    // Memory model: combinational read data while ce&r&oe
    always_comb begin
        mem_rdata = 8'h00;
        if (mem_ce && mem_r && mem_oe) begin
            mem_rdata = mem_wr[mem_addr] ? mem_arr[mem_addr] : seed_byte(mem_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction, entered and left at a negedge with the DUT idle
    task automatic do_req(input bit wr, input bit wd, input logic [15:0] addr,
                          input logic [15:0] wdata, input int hold, input bit keep_valid);
        int          last;
        bit          ok;
        logic [15:0] er;
        int          elat, ece, k, nce;
        logic [15:0] ea;
        last = int'(addr) + (wd ? 1 : 0);
        ok   = (last <= 1024);
        er   = 16'h0000;
        if (!ok) begin
            elat = 1; ece = 0;
        end else begin
            elat = wd ? 3 : 2;
            ece  = wd ? 2 : 1;
            if (wr) begin
                ref_mem[addr] = wdata[7:0];
                if (wd) ref_mem[addr + 16'd1] = wdata[15:8];
            end else begin
                er = wd ? {ref_mem[addr + 16'd1], ref_mem[addr]} : {8'h00, ref_mem[addr]};
            end
        end
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_word = wd; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        if (!keep_valid) req_valid = 1'b0;
        k = 0; nce = 0;
        do begin
            @(negedge clk);
            k++;
            if (mem_ce) begin
                ea = addr + 16'(nce);
                chk("acc_addr", mem_addr, ea);
                chk("acc_w", mem_w, wr);
                chk("acc_r", mem_r, !wr);
                chk("acc_oe", mem_oe, !wr);
                if (wr) chk("acc_wdata", mem_wdata, (nce == 0) ? wdata[7:0] : wdata[15:8]);
                nce++;
            end
            if (!resp_valid) begin
                chk("busy_active", busy, 1);
                chk("req_ready_busy", req_ready, 0);
            end
        end while (!resp_valid && k < 8);
        chk("resp_valid", resp_valid, 1);
        chk("latency", k, elat);
        chk("ce_cycles", nce, ece);
        chk("resp_rdata", resp_rdata, er);
        chk("resp_err", resp_err, !ok);
        chk("resp_req_ready", req_ready, 0);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_rdata", resp_rdata, er);
            chk("hold_err", resp_err, !ok);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_ce", mem_ce, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("post_valid", resp_valid, 0);
        chk("post_req_ready", req_ready, 1);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        logic [15:0] a;
        int sel;
        for (int i = 0; i < 65536; i++) ref_mem[i] = seed_byte(i[15:0]);
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0;
        req_addr = 16'h0000; req_wdata = 16'h0000; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_rdata", resp_rdata, 16'h0000);
        chk("rst_busy", busy, 0);
        chk("rst_mem_strobes", {mem_ce, mem_w, mem_r, mem_oe}, 4'h0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);

        do_req(1'b1, 1'b0, 16'h0010, 16'h005A, 0, 1'b0);
        do_req(1'b0, 1'b0, 16'h0010, 16'h0000, 0, 1'b0);
        chk("t1_rdata_const", resp_rdata, 16'h005A);

        do_req(1'b1, 1'b1, 16'h0100, 16'hBEEF, 0, 1'b0);
        chk("t2_mem100", tb_mem_byte(16'h0100), 8'hEF);
        chk("t2_mem101", tb_mem_byte(16'h0101), 8'hBE);
        do_req(1'b0, 1'b1, 16'h0100, 16'h0000, 1, 1'b0);
        chk("t2_rdata_const", resp_rdata, 16'hBEEF);

        do_req(1'b0, 1'b0, 16'h0401, 16'h0000, 0, 1'b0);
        do_req(1'b0, 1'b1, 16'h0400, 16'h0000, 0, 1'b0);
        do_req(1'b1, 1'b1, 16'hFFFF, 16'h7777, 0, 1'b0);
        do_req(1'b1, 1'b1, 16'h03FF, 16'hA1B2, 0, 1'b0);
        do_req(1'b0, 1'b0, 16'h0400, 16'h0000, 0, 1'b0);

        do_req(1'b0, 1'b1, 16'h0100, 16'h0000, 3, 1'b1);
        do_req(1'b1, 1'b0, 16'h0033, 16'h00C4, 0, 1'b0);

        req_valid = 1'b1; req_write = 1'b1; req_word = 1'b1;
        req_addr = 16'h0020; req_wdata = 16'h1234;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("t5_lo_ce", mem_ce, 1);
        chk("t5_lo_addr", mem_addr, 16'h0020);
        chk("t5_lo_wdata", mem_wdata, 8'h34);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_hi_ce", mem_ce, 0);
        chk("t5_hi_w", mem_w, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("t5_req_ready", req_ready, 1);
        chk("t5_busy", busy, 0);
        chk("t5_resp_valid", resp_valid, 0);
        ref_mem[16'h0020] = 8'h34;
        chk("t5_mem20", tb_mem_byte(16'h0020), 8'h34);
        chk("t5_mem21", tb_mem_byte(16'h0021), ref_mem[16'h0021]);
        do_req(1'b0, 1'b1, 16'h0020, 16'h0000, 0, 1'b0);

        for (int t = 0; t < 6; t++)
            do_req(t[0], t[1], 16'h0200 + 16'(t), 16'(32'h3C00 + t), 0, 1'b1);
        req_valid = 1'b0;

        for (int t = 0; t < 200; t++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5)      a = 16'($urandom_range(0, 1024));
            else if (sel <= 7) a = 16'(1022 + $urandom_range(0, 4));
            else if (sel == 8) a = 16'($urandom);
            else               a = 16'hFFFF;
            do_req(1'($urandom), 1'($urandom), a, 16'($urandom),
                   $urandom_range(0, 3), 1'($urandom));
        end
        req_valid = 1'b0;

        for (int i = 0; i < 1026; i++)
            chk("mem_final", tb_mem_byte(i[15:0]), ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
